// File: rtl/c2c_pkg.sv
// Shared types and header decode for the C2C outbound link arbiter.
// Header layout: [16] op (1=write), [15:0] bursts-1, upper bits opaque.
package c2c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } arb_state_t;

    localparam int unsigned C2C_HDR_OP_BIT  = 16;
    localparam int unsigned C2C_HDR_LEN_LSB = 0;
    localparam int unsigned C2C_HDR_LEN_W   = 16;
    localparam int unsigned C2C_HDR_W       = 17;
    localparam int unsigned C2C_ADDR_WORDS  = 2;
    localparam int unsigned C2C_FLEN_W      = C2C_HDR_LEN_W + 2;
    localparam int unsigned C2C_STAT_W      = 16;

    // Total words in a frame: header + address words, plus data bursts for writes.
    function automatic logic [C2C_FLEN_W-1:0] c2c_frame_len(input logic [C2C_HDR_W-1:0] hdr);
        logic [C2C_FLEN_W-1:0] len;
        len = C2C_FLEN_W'(1 + C2C_ADDR_WORDS);
        if (hdr[C2C_HDR_OP_BIT]) begin
            len = len + C2C_FLEN_W'(hdr[C2C_HDR_LEN_LSB +: C2C_HDR_LEN_W]) + C2C_FLEN_W'(1);
        end
        return len;
    endfunction

endpackage

// File: rtl/c2c_rr_pick.sv
// Combinational round-robin search: first set request at or above i_ptr, wrapping.
module c2c_rr_pick
#(
    parameter int unsigned NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0]         i_req,
    input  logic [$clog2(NUM_SRC)-1:0] i_ptr,
    output logic [$clog2(NUM_SRC)-1:0] o_idx_c,
    output logic                       o_any_c
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    logic [IDX_W-1:0] w_idx_hi;
    logic [IDX_W-1:0] w_idx_lo;
    logic             w_hit_hi;

    // Descending scan leaves the lowest index in each region.
    always_comb begin
        w_idx_hi = '0;
        w_idx_lo = '0;
        w_hit_hi = 1'b0;
        for (int j = int'(NUM_SRC) - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_idx_lo = IDX_W'(j);
                if (IDX_W'(j) >= i_ptr) begin
                    w_idx_hi = IDX_W'(j);
                    w_hit_hi = 1'b1;
                end
            end
        end
    end

    assign o_idx_c = w_hit_hi ? w_idx_hi : w_idx_lo;
    assign o_any_c = |i_req;

endmodule

// File: rtl/c2c_tx_arbiter.sv
// Frame-atomic round-robin arbiter onto the single outbound C2C link stream.
// Optional per-source frame counters: define C2C_TX_ARB_STATS_EN.
module c2c_tx_arbiter
    import c2c_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            in_valid,
    output logic [NUM_SRC-1:0]            in_ready,
    input  logic [NUM_SRC*DATA_W-1:0]     in_bits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_bits,
    output logic [$clog2(NUM_SRC)-1:0]    grant_idx,
    output logic                          busy
`ifdef C2C_TX_ARB_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [NUM_SRC*C2C_STAT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned REM_W = LEN_W + 2;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_ptr;
    logic [REM_W-1:0] r_rem;
    logic             r_busy;

    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic             w_hs;
    logic             w_last;
    logic [REM_W-1:0] w_first_rem;
    logic [DATA_W-1:0] w_src_bits [NUM_SRC];

    c2c_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_idx_c (w_pick),
        .o_any_c (w_any)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_src_bits[i] = in_bits[i*DATA_W +: DATA_W];
        end
    end

    assign w_hs        = out_valid & out_ready;
    assign w_last      = (r_state == BODY) && (r_rem == REM_W'(1));
    assign w_first_rem = REM_W'(c2c_frame_len(out_bits[C2C_HDR_W-1:0])) - REM_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)           w_state_nxt = HDR;
            HDR:     if (w_hs)            w_state_nxt = BODY;
            BODY:    if (w_hs && w_last)  w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // Zero-latency pass-through of the granted source while a frame is open.
    always_comb begin
        out_valid = 1'b0;
        out_bits  = '0;
        in_ready  = '0;
        if (r_state != IDLE) begin
            out_valid          = in_valid[r_grant];
            out_bits           = w_src_bits[r_grant];
            in_ready[r_grant]  = out_ready;
        end
    end

    // Grant, remaining-word count and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_busy  <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_hs) begin
                        r_rem <= w_first_rem;
                    end
                end
                BODY: begin
                    if (w_hs) begin
                        r_rem <= r_rem - REM_W'(1);
                        if (w_last) begin
                            r_busy <= 1'b0;
                            r_ptr  <= (r_grant == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx = r_grant;
    assign busy      = r_busy;

`ifdef C2C_TX_ARB_STATS_EN
    // Per-source completed-frame counters; clear wins over a same-cycle increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (stats_clr) begin
            frame_cnt <= '0;
        end else if (w_hs && w_last) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (IDX_W'(i) == r_grant) begin
                    frame_cnt[i*C2C_STAT_W +: C2C_STAT_W] <=
                        frame_cnt[i*C2C_STAT_W +: C2C_STAT_W] + C2C_STAT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_c2c_tx_arbiter.sv
// Scoreboard bench for c2c_tx_arbiter: frame-level round-robin reference model,
// randomized sources and link backpressure.
module tb_c2c_tx_arbiter;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned IDX_W   = $clog2(NUM_SRC);
    localparam int          WAIT_MAX = 3000;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [NUM_SRC-1:0]          in_valid;
    logic [NUM_SRC-1:0]          in_ready;
    logic [NUM_SRC*DATA_W-1:0]   in_bits;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_bits;
    logic [IDX_W-1:0]            grant_idx;
    logic                        busy;
`ifdef C2C_TX_ARB_STATS_EN
    logic                        stats_clr;
    logic [NUM_SRC*16-1:0]       frame_cnt;
`endif

    c2c_tx_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef C2C_TX_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] w;
        bit          first;
    } wd_t;

    typedef struct {
        int          src;
        logic [31:0] w;
        bit          last;
    } exp_t;

    wd_t  stage [NUM_SRC][$];
    wd_t  src_q [NUM_SRC][$];
    exp_t exp_q [$];

    int n_cmp = 0;
    int n_fail = 0;
    int n_hs = 0;
    int mdl_ptr = 0;
    int mdl_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] hs_s = '0;
    int rdy_mode = 0;
    bit gap_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add_frame(input int s, input bit op, input logic [15:0] bm1,
                             input logic [14:0] hi, input logic [31:0] ahi,
                             input logic [31:0] alo, input logic [31:0] dbase);
        wd_t x;
        x.w = {hi, op, bm1}; x.first = 1'b1; stage[s].push_back(x);
        x.first = 1'b0;
        x.w = ahi; stage[s].push_back(x);
        x.w = alo; stage[s].push_back(x);
        if (op) begin
            for (int k = 0; k <= int'(bm1); k++) begin
                x.w = dbase + 32'(k);
                stage[s].push_back(x);
            end
        end
    endtask

    // Frame-level model: whole frames leave in round-robin order over non-empty sources.
    task automatic load_batch();
        wd_t  tmp [NUM_SRC][$];
        exp_t e;
        int   ptr;
        int   g;
        ptr = mdl_ptr;
        for (int s = 0; s < NUM_SRC; s++) tmp[s] = stage[s];
        forever begin
            g = -1;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (g < 0 && tmp[(ptr + k) % NUM_SRC].size() > 0) g = (ptr + k) % NUM_SRC;
            end
            if (g < 0) break;
            do begin
                e.src  = g;
                e.w    = tmp[g][0].w;
                void'(tmp[g].pop_front());
                e.last = (tmp[g].size() == 0) || tmp[g][0].first;
                exp_q.push_back(e);
            end while (!e.last);
            mdl_cnt[g]++;
            ptr = (g + 1) % NUM_SRC;
        end
        mdl_ptr = ptr;
        for (int s = 0; s < NUM_SRC; s++) begin
            foreach (stage[s][i]) src_q[s].push_back(stage[s][i]);
            stage[s].delete();
        end
    endtask

    task automatic wait_done(input string name);
        int  cyc;
        bit  pend;
        cyc = 0;
        forever begin
            pend = (exp_q.size() != 0) || busy;
            for (int s = 0; s < NUM_SRC; s++) if (src_q[s].size() != 0) pend = 1'b1;
            if (!pend || cyc >= WAIT_MAX) break;
            @(negedge clock);
            cyc++;
        end
        repeat (2) @(negedge clock);
        n_cmp++;
        if (cyc >= WAIT_MAX) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, exp_q.size(), cyc);
        end
    endtask

    task automatic check_stats(input string name);
`ifdef C2C_TX_ARB_STATS_EN
        for (int s = 0; s < NUM_SRC; s++) begin
            check($sformatf("%s_cnt%0d", name, s), 32'(frame_cnt[s*16 +: 16]), 32'(16'(mdl_cnt[s])));
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // Source drivers and link ready, updated just after each rising edge.
    initial begin
        in_valid  = '0;
        in_bits   = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (hs_s[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            end
            hs_s = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (src_q[s].size() > 0) begin
                    in_valid[s] = src_q[s][0].first ? 1'b1 :
                                  (gap_en ? ($urandom_range(0, 3) != 0) : 1'b1);
                    in_bits[s*DATA_W +: DATA_W] = src_q[s][0].w;
                end else begin
                    in_valid[s] = 1'b0;
                    in_bits[s*DATA_W +: DATA_W] = $urandom;
                end
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each link handshake.
    bit          prev_busy = 0;
    bit          prev_req = 0;
    bit          prev_stall = 0;
    bit          prev_last = 0;
    logic [31:0] prev_bits = '0;

    always @(negedge clock) begin : monitor
        exp_t             e;
        logic [NUM_SRC-1:0] exp_rdy;
        bit               hs;
        bit               is_last;
        if (reset) begin
            prev_busy = 0; prev_req = 0; prev_stall = 0; prev_last = 0;
            hs_s = '0;
        end else begin
            hs      = out_valid && out_ready;
            is_last = 1'b0;
            hs_s    = in_valid & in_ready;
            if (!busy) begin
                check("idle_quiet", {out_bits[29:0], out_valid, 1'b0} | 32'(in_ready), 32'h0);
            end else begin
                exp_rdy = '0;
                exp_rdy[grant_idx] = out_ready;
                check("in_ready", 32'(in_ready), 32'(exp_rdy));
                check("out_valid", 32'(out_valid), 32'(in_valid[grant_idx]));
            end
            if (prev_last) check("bubble", 32'(busy), 32'h0);
            else if (!prev_busy && prev_req) check("grant_latency", 32'(busy), 32'h1);
            if (prev_stall && busy) check("stall_hold", out_bits, prev_bits);
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", out_bits);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bits", out_bits, e.w);
                    check("grant_idx", 32'(grant_idx), 32'(e.src));
                    is_last = e.last;
                end
            end
            prev_busy  = busy;
            prev_req   = |in_valid;
            prev_stall = out_valid && !out_ready;
            prev_bits  = out_bits;
            prev_last  = hs && is_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d words outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        for (int s = 0; s < NUM_SRC; s++) mdl_cnt[s] = 0;
`ifdef C2C_TX_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        reset = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant_idx), 32'h0);
        check("rst_out_bits", out_bits, 32'h0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;

        // Single-burst write from source 0, link always ready.
        add_frame(0, 1'b1, 16'd0, 15'd0, 32'h0, 32'h0, 32'h11111111);
        load_batch();
        wait_done("t1");

        // Two back-to-back reads from source 1; second has junk in its length field.
        add_frame(1, 1'b0, 16'd0, 15'd0, 32'h0, 32'h24, 32'h0);
        add_frame(1, 1'b0, 16'h0005, 15'h7abc, 32'h0, 32'h48, 32'h0);
        load_batch();
        wait_done("t2");

        // All sources contend with 4-burst writes.
        for (int s = 0; s < NUM_SRC; s++)
            add_frame(s, 1'b1, 16'd3, 15'h1234, 32'h0, 32'h100 * s, 32'h10 * s);
        load_batch();
        wait_done("t3");

        // Toggling link ready over a 7-word frame.
        rdy_mode = 1;
        add_frame(2, 1'b1, 16'd3, 15'h0, 32'hdead0000, 32'hbeef, 32'ha0);
        load_batch();
        wait_done("t4");
        check_stats("early");

        // Randomized batches: mixed ops, sizes, valid gaps and backpressure.
        for (int b = 0; b < 20; b++) begin
            rdy_mode = int'($urandom_range(0, 2));
            gap_en   = bit'($urandom_range(0, 1));
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int f = int'($urandom_range(0, 2)); f > 0; f--) begin
                    add_frame(s, bit'($urandom_range(0, 1)), 16'($urandom_range(0, 5)),
                              15'($urandom), $urandom, $urandom, $urandom);
                end
            end
            load_batch();
            wait_done("rand");
        end

        // Long write frame.
        rdy_mode = 2;
        add_frame(1, 1'b1, 16'd255, 15'h7fff, 32'h1, 32'h2, 32'h5000);
        load_batch();
        wait_done("long");
        check_stats("mid");

        // Reset in the middle of a frame.
        rdy_mode = 0;
        gap_en   = 1'b0;
        add_frame(1, 1'b1, 16'd3, 15'h0, 32'h0, 32'h80, 32'h900);
        load_batch();
        base = n_hs;
        cyc  = 0;
        while (n_hs < base + 2 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("rst_mid_reach", 32'(n_hs >= base + 2), 32'h1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_grant", 32'(grant_idx), 32'h0);
        exp_q.delete();
        for (int s = 0; s < NUM_SRC; s++) begin
            src_q[s].delete();
            mdl_cnt[s] = 0;
        end
        mdl_ptr = 0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;

        // After reset the pointer is back at source 0.
        add_frame(1, 1'b0, 16'd0, 15'h0, 32'h0, 32'h10, 32'h0);
        add_frame(0, 1'b1, 16'd1, 15'h0, 32'h0, 32'h20, 32'h700);
        add_frame(2, 1'b0, 16'd0, 15'h0, 32'h0, 32'h30, 32'h0);
        load_batch();
        wait_done("post_rst");
        check_stats("post_rst");

`ifdef C2C_TX_ARB_STATS_EN
        @(posedge clock); #1 stats_clr = 1'b1;
        @(posedge clock); #1 stats_clr = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) mdl_cnt[s] = 0;
        for (int f = 0; f < 3; f++) add_frame(2, 1'b0, 16'd0, 15'h0, 32'h0, 32'(f), 32'h0);
        add_frame(0, 1'b1, 16'd0, 15'h0, 32'h0, 32'h4, 32'h44);
        load_batch();
        wait_done("stats");
        check_stats("stats");
        @(posedge clock); #1 stats_clr = 1'b1;
        @(posedge clock); #1 stats_clr = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) mdl_cnt[s] = 0;
        @(negedge clock);
        check_stats("stats_clr");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
